regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter_pkg.sv | 12 +
 rtl/regfile_wb_arbiter_wb_fifo.sv | 92 +++++++++
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and constants for the regfile writeback arbiter.
// Optional pending-write compare is enabled with WB_PENDING_CHECK_EN.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned REG_DW   = 32;
  localparam int unsigned WB_DEPTH = 2;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Per-source writeback FIFO: drops addr-0 writes, exposes head and ready.
// With WB_PENDING_CHECK_EN it also exports per-slot valid/address for hazard compare.
module regfile_wb_arbiter_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = REG_DW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_valid,
  input  logic [AW-1:0]             push_addr,
  input  logic [DW-1:0]             push_data,
  input  logic                      pop,
  output logic                      ready,
  output logic                      empty,
  output logic [AW-1:0]             head_addr,
  output logic [DW-1:0]             head_data
`ifdef WB_PENDING_CHECK_EN
  ,
  output logic [DEPTH-1:0]          entry_valid,
  output logic [DEPTH-1:0][AW-1:0]  entry_addr
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem_addr_q [DEPTH];
  logic [AW-1:0] mem_addr_d [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];
  logic [DW-1:0] mem_data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_c;
  logic          pop_c;

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ready      = (rst != RST_ENABLE) && (count_q < CW'(DEPTH));
    empty      = (count_q == '0);
    head_addr  = mem_addr_q[rd_ptr_q];
    head_data  = mem_data_q[rd_ptr_q];
    // Address 0 completes the handshake but is never stored.
    push_c     = push_valid && ready && (push_addr != '0);
    pop_c      = pop && !empty;
    if (push_c) begin
      mem_addr_d[wr_ptr_q] = push_addr;
      mem_data_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_c) - CW'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

`ifdef WB_PENDING_CHECK_EN
  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    entry_valid = '0;
    entry_addr  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_valid[i] = CW'(PW'(i) - rd_ptr_q) < count_q;
      entry_addr[i]  = mem_addr_q[i];
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between sources A and B.
// Define WB_PENDING_CHECK_EN to add q_addr/q_pend in-flight hazard ports.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = REG_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          grant_b,
  output logic          idle
`ifdef WB_PENDING_CHECK_EN
  ,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_pend1,
  output logic          q_pend2
`endif
);

  logic          a_empty, b_empty;
  logic [AW-1:0] a_head_addr, b_head_addr;
  logic [DW-1:0] a_head_data, b_head_data;
  logic          pop_a, pop_b;
  logic          last_b_q, last_b_d;

`ifdef WB_PENDING_CHECK_EN
  logic [DEPTH-1:0]         a_entry_valid, b_entry_valid;
  logic [DEPTH-1:0][AW-1:0] a_entry_addr, b_entry_addr;
`endif

  regfile_wb_arbiter_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_a (
    .clk        (clk),
    .rst        (rst),
    .push_valid (a_valid),
    .push_addr  (a_addr),
    .push_data  (a_data),
    .pop        (pop_a),
    .ready      (a_ready),
    .empty      (a_empty),
    .head_addr  (a_head_addr),
    .head_data  (a_head_data)
`ifdef WB_PENDING_CHECK_EN
    ,
    .entry_valid(a_entry_valid),
    .entry_addr (a_entry_addr)
`endif
  );

  regfile_wb_arbiter_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_b (
    .clk        (clk),
    .rst        (rst),
    .push_valid (b_valid),
    .push_addr  (b_addr),
    .push_data  (b_data),
    .pop        (pop_b),
    .ready      (b_ready),
    .empty      (b_empty),
    .head_addr  (b_head_addr),
    .head_data  (b_head_data)
`ifdef WB_PENDING_CHECK_EN
    ,
    .entry_valid(b_entry_valid),
    .entry_addr (b_entry_addr)
`endif
  );

  // B wins a tie only when A had the previous grant.
  always_comb begin
    we       = (rst != RST_ENABLE) && (!a_empty || !b_empty);
    grant_b  = we && !b_empty && (a_empty || !last_b_q);
    waddr    = '0;
    wdata    = '0;
    idle     = (rst == RST_ENABLE) || (a_empty && b_empty);
    pop_a    = we && !grant_b;
    pop_b    = grant_b;
    last_b_d = last_b_q;
    if (we == WRITE_ENABLE) begin
      waddr    = grant_b ? b_head_addr : a_head_addr;
      wdata    = grant_b ? b_head_data : a_head_data;
      last_b_d = grant_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

`ifdef WB_PENDING_CHECK_EN
  // Includes the head being written this cycle, so decode stalls one more cycle.
  always_comb begin
    q_pend1 = 1'b0;
    q_pend2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (a_entry_valid[i] && (a_entry_addr[i] == q_addr1)) q_pend1 = 1'b1;
      if (b_entry_valid[i] && (b_entry_addr[i] == q_addr1)) q_pend1 = 1'b1;
      if (a_entry_valid[i] && (a_entry_addr[i] == q_addr2)) q_pend2 = 1'b1;
      if (b_entry_valid[i] && (b_entry_addr[i] == q_addr2)) q_pend2 = 1'b1;
    end
    if (q_addr1 == '0) q_pend1 = 1'b0;
    if (q_addr2 == '0) q_pend2 = 1'b0;
  end
`endif

endmodule
